// File: rtl/alu_regfile_seq_if.sv
// Register-access bus and result/status outputs of alu_regfile_seq.
//   enable  : register access request, sampled on each rising clock edge
//   rd_wr   : 1 = read, 0 = write
//   addr    : register address
//   wr_data : write data
//   rd_data : registered read data (one edge after the sampled read)
//   res_out : registered ALU result, 2*DATA_WIDTH bits
//   busy    : operation in progress
//   done    : sticky completion flag (STATUS[1])
// master drives the requests; slave is the register file / ALU.
interface alu_regfile_seq_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
);
  logic                    enable;
  logic                    rd_wr;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic [2*DATA_WIDTH-1:0] res_out;
  logic                    busy;
  logic                    done;

  modport master (
    output enable, rd_wr, addr, wr_data,
    input  rd_data, res_out, busy, done
  );

  modport slave (
    input  enable, rd_wr, addr, wr_data,
    output rd_data, res_out, busy, done
  );
endinterface

// File: rtl/alu_regfile_seq.sv
// Register-mapped ALU with a multi-cycle restoring divider.
//   clk : single clock, all state updates on the rising edge
//   rst : synchronous, active-high reset
//   bus : alu_regfile_seq_if slave port (register access, result and status)
// Register map: 0 A, 1 B, 2 OPER, 3 CTRL (write bit0 = EXECUTE), 4 STATUS,
// 5 RES_LO, 6 RES_HI, others unmapped (read 0, writes ignored).
// STATUS: [0] busy, [1] done, [2] div_by_zero, [3] invalid_op, [4] overrun.
module alu_regfile_seq #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input logic                clk,
  input logic                rst,
  alu_regfile_seq_if.slave   bus
);

  localparam int unsigned DW   = DATA_WIDTH;
  localparam int unsigned RW   = 2 * DATA_WIDTH;
  localparam int unsigned CntW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [ADDR_WIDTH-1:0] AddrA      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] AddrB      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] AddrOper   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] AddrCtrl   = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] AddrStatus = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] AddrResLo  = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] AddrResHi  = ADDR_WIDTH'(6);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  localparam logic [3:0] OpDiv = 4'd4;

  // Programmer-visible registers
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   oper_q, oper_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic [RW-1:0]   res_q, res_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic            inv_q, inv_d;
  logic            ovr_q, ovr_d;

  // Operation snapshot and divider state
  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   op_a_q, op_a_d;
  logic [DW-1:0]   op_b_q, op_b_d;
  logic [3:0]      op_code_q, op_code_d;
  logic [DW-1:0]   rem_q, rem_d;
  logic [DW-1:0]   quo_q, quo_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            acc_wr, acc_rd;
  logic            exec_req, start, busy;
  logic [DW-1:0]   status_w;
  logic [DW-1:0]   rd_mux;
  logic [RW-1:0]   alu_res;
  logic [RW-1:0]   a_ext, b_ext;
  logic [DW:0]     rem_shift, rem_diff;
  logic            q_bit;
  logic [DW-1:0]   rem_next, quo_next;

  assign acc_wr   = bus.enable & ~bus.rd_wr;
  assign acc_rd   = bus.enable & bus.rd_wr;
  assign exec_req = acc_wr && (bus.addr == AddrCtrl) && bus.wr_data[0];
  assign busy     = (state_q != StIdle);
  assign start    = exec_req && !busy;

  // Narrow DATA_WIDTH truncates the upper flags; wide ones zero-extend.
  assign status_w = DW'({ovr_q, inv_q, dbz_q, done_q, busy});

  always_comb begin
    rd_mux = '0;
    unique case (bus.addr)
      AddrA:      rd_mux = a_q;
      AddrB:      rd_mux = b_q;
      AddrOper:   rd_mux = oper_q;
      AddrStatus: rd_mux = status_w;
      AddrResLo:  rd_mux = res_q[DW-1:0];
      AddrResHi:  rd_mux = res_q[RW-1:DW];
      default:    rd_mux = '0;
    endcase
  end

  // Single-cycle ALU on the snapshot, zero-extended to the result width
  assign a_ext = {{DW{1'b0}}, op_a_q};
  assign b_ext = {{DW{1'b0}}, op_b_q};

  always_comb begin
    alu_res = '0;
    case (op_code_q)
      4'd1:    alu_res = a_ext + b_ext;
      4'd2:    alu_res = a_ext - b_ext;
      4'd3:    alu_res = a_ext * b_ext;
      4'd5:    alu_res = a_ext & b_ext;
      4'd6:    alu_res = a_ext | b_ext;
      4'd7:    alu_res = a_ext ^ b_ext;
      default: alu_res = '0;
    endcase
  end

  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor when it fits.
  assign rem_shift = {rem_q, quo_q[DW-1]};
  assign rem_diff  = rem_shift - {1'b0, op_b_q};
  assign q_bit     = (rem_shift >= {1'b0, op_b_q});
  assign rem_next  = q_bit ? rem_diff[DW-1:0] : rem_shift[DW-1:0];
  assign quo_next  = {quo_q[DW-2:0], q_bit};

  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    oper_d    = oper_q;
    rd_data_d = rd_data_q;
    res_d     = res_q;
    done_d    = done_q;
    dbz_d     = dbz_q;
    inv_d     = inv_q;
    ovr_d     = ovr_q;
    state_d   = state_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_code_d = op_code_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;

    // Register access path
    if (acc_wr) begin
      unique case (bus.addr)
        AddrA:    a_d    = bus.wr_data;
        AddrB:    b_d    = bus.wr_data;
        AddrOper: oper_d = bus.wr_data;
        default:  ;
      endcase
    end
    if (acc_rd) begin
      rd_data_d = rd_mux;
      // Cleared here so that a completion at the same edge (below) wins.
      if (bus.addr == AddrStatus) done_d = 1'b0;
    end
    if (exec_req && busy) ovr_d = 1'b1;

    // Operation sequencing
    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d    = a_q;
          op_b_d    = b_q;
          op_code_d = oper_q[3:0];
          done_d    = 1'b0;
          dbz_d     = 1'b0;
          inv_d     = 1'b0;
          ovr_d     = 1'b0;
          if ((oper_q[3:0] == OpDiv) && (b_q != '0)) begin
            state_d = StDiv;
            rem_d   = '0;
            quo_d   = a_q;
            cnt_d   = '0;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        state_d = StIdle;
        done_d  = 1'b1;
        if (op_code_q == OpDiv) begin
          // Only a zero divisor reaches this state with the divide opcode
          res_d = {op_a_q, {DW{1'b1}}};
          dbz_d = 1'b1;
        end else if (op_code_q[3]) begin
          inv_d = 1'b1;
        end else begin
          res_d = alu_res;
        end
      end
      StDiv: begin
        rem_d = rem_next;
        quo_d = quo_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(DW - 1)) begin
          state_d = StIdle;
          res_d   = {rem_next, quo_next};
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '1;
      b_q       <= '1;
      oper_q    <= '1;
      rd_data_q <= '0;
      res_q     <= '0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      inv_q     <= 1'b0;
      ovr_q     <= 1'b0;
      state_q   <= StIdle;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_code_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      oper_q    <= oper_d;
      rd_data_q <= rd_data_d;
      res_q     <= res_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      inv_q     <= inv_d;
      ovr_q     <= ovr_d;
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_code_q <= op_code_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.res_out = res_q;
  assign bus.busy    = busy;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_alu_regfile_seq.sv
// Directed bench for alu_regfile_seq (DATA_WIDTH=8, ADDR_WIDTH=3).
module tb_alu_regfile_seq;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 clk = ~clk;

  alu_regfile_seq_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

  alu_regfile_seq #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Each access or tick consumes exactly one rising edge; returns 1ns after it.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.enable  = 1'b1;
    bus.rd_wr   = 1'b0;
    bus.addr    = a;
    bus.wr_data = d;
    @(posedge clk);
    #1;
    bus.enable  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.enable = 1'b1;
    bus.rd_wr  = 1'b1;
    bus.addr   = a;
    @(posedge clk);
    #1;
    d          = bus.rd_data;
    bus.enable = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    int n;

    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.rd_wr   = 1'b0;
    bus.addr    = '0;
    bus.wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", bus.rd_data, 8'h00);
    check("rst_res_out", bus.res_out, 16'h0000);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, d); check("rst_A", d, 8'hFF);
    rd(3'd4, d); check("rst_STATUS", d, 8'h00);

    // Add with carry into the upper byte
    wr(3'd0, 8'hFF); wr(3'd1, 8'h01); wr(3'd2, 8'h01); wr(3'd3, 8'h01);
    check("add_busy", bus.busy, 1'b1);
    tick();
    check("add_busy_end", bus.busy, 1'b0);
    check("add_res", bus.res_out, 16'h0100);
    check("add_done", bus.done, 1'b1);
    rd(3'd4, d); check("add_STATUS", d, 8'h02);
    check("add_done_clr", bus.done, 1'b0);

    // Subtract wraps modulo 2^16, multiply full width
    wr(3'd0, 8'h03); wr(3'd1, 8'h05); wr(3'd2, 8'h02); wr(3'd3, 8'h01); tick();
    check("sub_res", bus.res_out, 16'hFFFE);
    wr(3'd0, 8'hFF); wr(3'd1, 8'hFF); wr(3'd2, 8'h03); wr(3'd3, 8'h01); tick();
    check("mul_res", bus.res_out, 16'hFE01);
    rd(3'd5, d); check("mul_RES_LO", d, 8'h01);
    rd(3'd6, d); check("mul_RES_HI", d, 8'hFE);

    // Division 200/7 with a B write and a second EXECUTE while busy
    wr(3'd0, 8'd200); wr(3'd1, 8'd7); wr(3'd2, 8'h04); wr(3'd3, 8'h01);
    check("div_busy", bus.busy, 1'b1);
    tick();
    wr(3'd1, 8'h00);
    wr(3'd3, 8'h01);
    n = 0;
    while (bus.busy && n < 20) begin
      tick();
      n++;
    end
    check("div_cycles_after_overrun", n, 5);
    check("div_res", bus.res_out, 16'h041C);
    rd(3'd4, d); check("div_STATUS", d, 8'h12);
    rd(3'd4, d); check("div_STATUS_again", d, 8'h10);

    // Divide by zero (B=0 from the write during the previous division)
    wr(3'd0, 8'h2A); wr(3'd3, 8'h01);
    check("dbz_busy", bus.busy, 1'b1);
    tick();
    check("dbz_busy_end", bus.busy, 1'b0);
    check("dbz_res", bus.res_out, 16'h2AFF);
    rd(3'd4, d); check("dbz_STATUS", d, 8'h06);

    // Invalid opcode keeps the previous result
    wr(3'd2, 8'h09); wr(3'd3, 8'h01); tick();
    check("inv_res", bus.res_out, 16'h2AFF);
    rd(3'd4, d); check("inv_STATUS", d, 8'h0A);
    check("inv_done_clr", bus.done, 1'b0);
    rd(3'd4, d); check("inv_STATUS_again", d, 8'h08);

    // Bitwise ops and zero
    wr(3'd0, 8'hC3); wr(3'd1, 8'h5A);
    wr(3'd2, 8'h05); wr(3'd3, 8'h01); tick(); check("and_res", bus.res_out, 16'h0042);
    wr(3'd2, 8'h06); wr(3'd3, 8'h01); tick(); check("or_res", bus.res_out, 16'h00DB);
    wr(3'd2, 8'h07); wr(3'd3, 8'h01); tick(); check("xor_res", bus.res_out, 16'h0099);
    wr(3'd2, 8'h00); wr(3'd3, 8'h01); tick(); check("zero_res", bus.res_out, 16'h0000);

    // STATUS read at the completion edge: pre-edge value, done stays set
    wr(3'd0, 8'h10); wr(3'd1, 8'h20); wr(3'd2, 8'h01); wr(3'd3, 8'h01);
    rd(3'd4, d); check("same_edge_STATUS", d, 8'h01);
    check("same_edge_done", bus.done, 1'b1);
    check("same_edge_res", bus.res_out, 16'h0030);

    // CTRL/unmapped reads return 0; RO writes ignored
    rd(3'd3, d); check("rd_CTRL", d, 8'h00);
    rd(3'd7, d); check("rd_unmapped", d, 8'h00);
    wr(3'd5, 8'h55);
    rd(3'd5, d); check("ro_RES_LO", d, 8'h30);

    // Reset in the middle of a division
    wr(3'd0, 8'd200); wr(3'd1, 8'd7); wr(3'd2, 8'h04); wr(3'd3, 8'h01);
    tick(); tick(); tick();
    @(negedge clk);
    rst         = 1'b1;
    bus.enable  = 1'b1;
    bus.rd_wr   = 1'b0;
    bus.addr    = 3'd0;
    bus.wr_data = 8'h11;
    @(posedge clk);
    #1;
    bus.enable = 1'b0;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_res", bus.res_out, 16'h0000);
    check("midrst_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, d); check("midrst_A", d, 8'hFF);
    rd(3'd1, d); check("midrst_B", d, 8'hFF);
    rd(3'd2, d); check("midrst_OPER", d, 8'hFF);
    repeat (10) tick();
    check("midrst_no_result", bus.res_out, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
